fht_input_loader: RTL and testbench

FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

---
 rtl/fht_input_loader_pkg.sv | 15 +
 rtl/fht_bit_rev.sv | 14 +
 rtl/fht_input_loader.sv | 84 ++++++++
 tb/tb_fht_input_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fht_input_loader_pkg.sv
// Shared FHT defines: default widths and
// loader state encoding.
package fht_input_loader_pkg;

  localparam int DefDBit = 16;
  localparam int DefABit = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } loadState_t;

endpackage

// File: rtl/fht_bit_rev.sv
// Combinational bit reversal of a W-bit word.
// Output bit i takes input bit W-1-i.
module fht_bit_rev #(
  parameter int W = 10
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] reversed
);

  for (genvar i = 0; i < W; i++) begin : gRev
    assign reversed[i] = value[W-1-i];
  end

endmodule

// File: rtl/fht_input_loader.sv
// Loads a natural-order frame into four FHT
// banks in bit-reversed order, then starts the FHT.
module fht_input_loader
  import fht_input_loader_pkg::*;
#(
  parameter int D_BIT = DefDBit,
  parameter int A_BIT = DefABit
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iFHT_DONE,
  output logic             oBUSY,
  output logic             oOVERRUN
);

  localparam int CBit = A_BIT + 2;

  loadState_t state;
  loadState_t nextState;

  logic [CBit-1:0] cnt;
  logic [CBit-1:0] rev;
  logic            accept;
  logic            lastSample;

  fht_bit_rev #(
    .W(CBit)
  ) uBitRev (
    .value   (cnt),
    .reversed(rev)
  );

  assign oREADY     = (state == LOAD);
  assign oSTART     = (state == START);
  assign accept     = iVALID & oREADY;
  assign lastSample = accept & (&cnt);

  always_comb begin
    nextState = state;
    unique case (state)
      LOAD:  if (lastSample) nextState = FLUSH;
      FLUSH: nextState = START;
      START: nextState = WAIT;
      WAIT:  if (iFHT_DONE) nextState = LOAD;
      default: nextState = LOAD;
    endcase
  end

  // cnt wraps to 0 on the last sample, so the
  // next frame already starts at index 0.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= LOAD;
      cnt      <= '0;
      oWE      <= '0;
      oDATA    <= '0;
      oADDR_WR <= '0;
      oBUSY    <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      state <= nextState;
      oWE   <= '0;
      if (accept) begin
        cnt      <= cnt + 1'b1;
        oDATA    <= iDATA;
        oADDR_WR <= rev[CBit-1:2];
        oWE      <= 4'b0001 << rev[1:0];
        oBUSY    <= 1'b1;
      end
      if (state == WAIT && iFHT_DONE)
        oBUSY <= 1'b0;
      if (state == WAIT && iVALID)
        oOVERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader
// with A_BIT=2 (16-sample frames).
module tb_fht_input_loader;

  localparam int DB = 16;
  localparam int AB = 2;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic [DB-1:0] iDATA;
  logic          iVALID;
  logic          oREADY;
  logic [DB-1:0] oDATA;
  logic [AB-1:0] oADDR_WR;
  logic [3:0]    oWE;
  logic          oSTART;
  logic          iFHT_DONE;
  logic          oBUSY;
  logic          oOVERRUN;

  int tests = 0;
  int fails = 0;

  // 4-bit reversal of 0..15, worked out by hand
  int revTab [16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                      1, 9, 5, 13, 3, 11, 7, 15};

  fht_input_loader #(
    .D_BIT(DB),
    .A_BIT(AB)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iDATA    (iDATA),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .oDATA    (oDATA),
    .oADDR_WR (oADDR_WR),
    .oWE      (oWE),
    .oSTART   (oSTART),
    .iFHT_DONE(iFHT_DONE),
    .oBUSY    (oBUSY),
    .oOVERRUN (oOVERRUN)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkWrite(input string tag,
                            input int idx,
                            input logic [15:0] d);
    int r;
    r = revTab[idx];
    check({tag, ".we"}, oWE, 32'(1 << (r % 4)));
    check({tag, ".addr"}, oADDR_WR, 32'(r / 4));
    check({tag, ".data"}, oDATA, d);
  endtask

  task automatic streamFrame(input logic [15:0] base);
    for (int k = 0; k < 16; k++) begin
      iVALID = 1'b1;
      iDATA  = base + 16'(k);
      step();
      checkWrite($sformatf("s%0d", k), k, base + 16'(k));
      check($sformatf("rdy%0d", k), oREADY,
            (k < 15) ? 32'd1 : 32'd0);
      check($sformatf("st%0d", k), oSTART, 0);
    end
    iVALID = 1'b0;
  endtask

  task automatic afterFrame();
    iVALID = 1'b0;
    step();
    check("startPulse", oSTART, 1);
    check("startWe", oWE, 0);
    check("startRdy", oREADY, 0);
    step();
    check("waitStart", oSTART, 0);
    check("waitBusy", oBUSY, 1);
    check("waitRdy", oREADY, 0);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".we"}, oWE, 0);
    check({tag, ".data"}, oDATA, 0);
    check({tag, ".addr"}, oADDR_WR, 0);
    check({tag, ".start"}, oSTART, 0);
    check({tag, ".busy"}, oBUSY, 0);
    check({tag, ".ovr"}, oOVERRUN, 0);
    check({tag, ".rdy"}, oREADY, 1);
  endtask

  initial begin
    int acc;
    int cyc;
    logic v;

    iRESET    = 1'b1;
    iVALID    = 1'b0;
    iDATA     = '0;
    iFHT_DONE = 1'b0;
    step();
    checkResetState("rst");
    iRESET = 1'b0;
    step();
    check("idleWe", oWE, 0);
    check("idleBusy", oBUSY, 0);

    streamFrame(16'hA000);
    afterFrame();

    // drive samples while waiting for the FHT
    for (int i = 0; i < 3; i++) begin
      iVALID = 1'b1;
      iDATA  = 16'h5555;
      step();
      check("ovrWe", oWE, 0);
      check("ovrFlag", oOVERRUN, 1);
      check("ovrRdy", oREADY, 0);
    end
    iVALID    = 1'b0;
    iFHT_DONE = 1'b1;
    step();
    iFHT_DONE = 1'b0;
    check("doneRdy", oREADY, 1);
    check("doneBusy", oBUSY, 0);
    check("doneOvr", oOVERRUN, 1);

    // gapped frame, DONE pulse in LOAD ignored
    acc = 0;
    cyc = 0;
    while (acc < 16 && cyc < 200) begin
      v = (cyc % 4 == 0) || (cyc % 4 == 3);
      iVALID    = v;
      iDATA     = 16'hB000 + 16'(acc);
      iFHT_DONE = (cyc == 5);
      step();
      if (v) begin
        checkWrite($sformatf("g%0d", acc), acc,
                   16'hB000 + 16'(acc));
        acc++;
      end else begin
        check("gapWe", oWE, 0);
      end
      if (cyc == 5) begin
        check("loadDoneRdy", oREADY, 1);
        check("loadDoneBusy", oBUSY, 1);
      end
      cyc++;
    end
    iFHT_DONE = 1'b0;
    check("gapCount", acc, 16);
    afterFrame();
    check("gapOvrSticky", oOVERRUN, 1);

    iFHT_DONE = 1'b1;
    step();
    iFHT_DONE = 1'b0;
    check("backToLoad", oREADY, 1);

    // partial frame then reset
    for (int k = 0; k < 7; k++) begin
      iVALID = 1'b1;
      iDATA  = 16'hD000 + 16'(k);
      step();
    end
    check("partBusy", oBUSY, 1);
    iVALID = 1'b0;
    iRESET = 1'b1;
    step();
    checkResetState("midRst");
    iRESET = 1'b0;

    streamFrame(16'hC000);
    afterFrame();
    step();
    check("noExtraStart", oSTART, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
